// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, load-use bubble and optional multicycle divide hold (macro DIV_MULTICYCLE_EN)
module id_ex_stage #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [4:0]  id_alu_opcode,
    input  logic        id_use_imm,
    input  logic        id_use_pc,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd_addr,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd_addr,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    input  logic        stall_in,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [4:0]  alu_opcode,
    output logic        ex_valid,
    output logic        ex_done,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_rd_addr,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_store_data,
    output logic        id_stall
);

`ifdef DIV_MULTICYCLE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BUSY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [4:0]  opcode;
        logic        use_imm;
        logic        use_pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } stage_t;

    stage_t      stage_q, stage_d, stage_in;
    state_t      state_q, state_d;
    logic        load_use;
    logic        busy_hold;
    logic [31:0] fwd_rs1, fwd_rs2;

`ifdef DIV_MULTICYCLE_EN
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       id_is_div;
    // DIV/DIVU/REM/REMU occupy opcodes 01100..01111
    assign id_is_div = (id_alu_opcode[4:2] == 3'b011);
    // Divide still has cycles to go: EX slot and decode are frozen
    assign busy_hold = (state_q == BUSY) && (cnt_q != 4'd0);
`else
    assign busy_hold = 1'b0;
`endif

    assign stage_in = '{
        valid:     id_valid,
        pc:        id_pc,
        imm:       id_imm,
        rs1_data:  id_rs1_data,
        rs2_data:  id_rs2_data,
        rs1_addr:  id_rs1_addr,
        rs2_addr:  id_rs2_addr,
        rd_addr:   id_rd_addr,
        opcode:    id_alu_opcode,
        use_imm:   id_use_imm,
        use_pc:    id_use_pc,
        reg_write: id_reg_write,
        mem_read:  id_mem_read,
        mem_write: id_mem_write
    };

    // Load in EX whose destination is read by the instruction in decode
    assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.rd_addr != 5'd0) &&
                      id_valid && ((stage_q.rd_addr == id_rs1_addr) || (stage_q.rd_addr == id_rs2_addr));

    assign id_stall = stall_in || load_use || busy_hold;

    // Operand forwarding: youngest producer (EX/MEM) wins over MEM/WB
    always_comb begin
        fwd_rs1 = stage_q.rs1_data;
        if (exmem_reg_write && (exmem_rd_addr != 5'd0) && (exmem_rd_addr == stage_q.rs1_addr)) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd_addr != 5'd0) && (memwb_rd_addr == stage_q.rs1_addr)) begin
            fwd_rs1 = memwb_result;
        end
        fwd_rs2 = stage_q.rs2_data;
        if (exmem_reg_write && (exmem_rd_addr != 5'd0) && (exmem_rd_addr == stage_q.rs2_addr)) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd_addr != 5'd0) && (memwb_rd_addr == stage_q.rs2_addr)) begin
            fwd_rs2 = memwb_result;
        end
    end

    // Next stage contents and FSM state: flush > hold > divide countdown > bubble > capture
    always_comb begin
        stage_d = stage_q;
        state_d = state_q;
`ifdef DIV_MULTICYCLE_EN
        cnt_d   = cnt_q;
`endif
        if (flush) begin
            stage_d = '0;
            state_d = IDLE;
`ifdef DIV_MULTICYCLE_EN
            cnt_d   = 4'd0;
`endif
        end else if (stall_in) begin
            stage_d = stage_q;
        end else if (busy_hold) begin
`ifdef DIV_MULTICYCLE_EN
            cnt_d = cnt_q - 4'd1;
`endif
        end else if (load_use) begin
            stage_d = '0;
            state_d = IDLE;
        end else begin
            stage_d = stage_in;
            state_d = id_valid ? RUN : IDLE;
`ifdef DIV_MULTICYCLE_EN
            cnt_d   = 4'd0;
            if (id_valid && id_is_div) begin
                state_d = BUSY;
                cnt_d   = DIV_LOAD;
            end
`endif
        end
    end

    // Stage register, FSM state and divide counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage_q <= '0;
            state_q <= IDLE;
`ifdef DIV_MULTICYCLE_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            stage_q <= stage_d;
            state_q <= state_d;
`ifdef DIV_MULTICYCLE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign alu_data1     = stage_q.use_pc  ? stage_q.pc  : fwd_rs1;
    assign alu_data2     = stage_q.use_imm ? stage_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_opcode    = stage_q.opcode;
    assign ex_pc         = stage_q.pc;
    assign ex_rd_addr    = stage_q.rd_addr;
    assign ex_valid      = stage_q.valid;
    assign ex_reg_write  = stage_q.valid && stage_q.reg_write;
    assign ex_mem_read   = stage_q.valid && stage_q.mem_read;
    assign ex_mem_write  = stage_q.valid && stage_q.mem_write;
    assign ex_done       = (state_q != IDLE) && !busy_hold;

endmodule
